// File: rtl/word_loader.sv
// rtl/word_loader.sv - splits a byte stream into words, loads each into the matcher buffer and reports the result
module word_loader #(
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] DELIM      = 8'h20,
  parameter int                    TIMEOUT    = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  m_rst_n,
  output logic                  m_cs,
  input  logic                  m_done,
  input  logic                  m_found,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  res_found,
  output logic                  res_timeout,
  output logic                  res_ovf,
  output logic [ADDR_WIDTH-1:0] res_len,
  output logic [7:0]            res_idx
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  localparam logic [2:0] S_COLLECT = 3'd0;
  localparam logic [2:0] S_TERM    = 3'd1;
  localparam logic [2:0] S_MRST    = 3'd2;
  localparam logic [2:0] S_START   = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_RESULT  = 3'd5;

  // One slot is always kept free for the zero terminator.
  localparam logic [ADDR_WIDTH-1:0] LEN_MAX = '1;
  localparam logic [TW-1:0]         T_LAST  = TW'(TIMEOUT - 1);

  logic [2:0]            state_q,   state_d;
  logic [ADDR_WIDTH-1:0] len_q,     len_d;
  logic                  ovf_q,     ovf_d;
  logic [TW-1:0]         timer_q,   timer_d;
  logic [7:0]            idx_q,     idx_d;
  logic                  found_q,   found_d;
  logic                  timeout_q, timeout_d;
  logic                  wr_en_q,   wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  m_rst_n_q, m_rst_n_d;
  logic                  m_cs_q,    m_cs_d;

  logic is_delim;
  logic accept;

  assign is_delim = (in_data == DELIM) || (in_data == '0);
  assign accept   = in_valid && (state_q == S_COLLECT);

  // Next-state, buffer write and result capture; matcher strobes are derived
  // from the next state so they line up with the MRST and START cycles.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    ovf_d     = ovf_q;
    timer_d   = timer_q;
    idx_d     = idx_q;
    found_d   = found_q;
    timeout_d = timeout_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      S_COLLECT: begin
        if (accept) begin
          if (is_delim) begin
            // A delimiter with an empty word is just padding between words.
            if (len_q != '0) begin
              wr_en_d   = 1'b1;
              wr_addr_d = base_addr + len_q;
              wr_data_d = '0;
              state_d   = S_TERM;
            end
          end else if (len_q != LEN_MAX) begin
            wr_en_d   = 1'b1;
            wr_addr_d = base_addr + len_q;
            wr_data_d = in_data;
            len_d     = len_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      S_TERM:  state_d = S_MRST;
      S_MRST:  state_d = S_START;
      S_START: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done seen on the last timer cycle still counts as a real answer.
        if (m_done) begin
          found_d   = m_found;
          timeout_d = 1'b0;
          state_d   = S_RESULT;
        end else if (timer_q == T_LAST) begin
          found_d   = 1'b0;
          timeout_d = 1'b1;
          state_d   = S_RESULT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RESULT: begin
        if (res_ready) begin
          len_d     = '0;
          ovf_d     = 1'b0;
          timeout_d = 1'b0;
          idx_d     = idx_q + 8'd1;
          state_d   = S_COLLECT;
        end
      end
      default: state_d = S_COLLECT;
    endcase
    m_rst_n_d = (state_d != S_MRST);
    m_cs_d    = (state_d == S_START);
  end

  // State and registered outputs; reset abandons any word in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_COLLECT;
      len_q     <= '0;
      ovf_q     <= 1'b0;
      timer_q   <= '0;
      idx_q     <= 8'd0;
      found_q   <= 1'b0;
      timeout_q <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      m_rst_n_q <= 1'b0;
      m_cs_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      ovf_q     <= ovf_d;
      timer_q   <= timer_d;
      idx_q     <= idx_d;
      found_q   <= found_d;
      timeout_q <= timeout_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      m_rst_n_q <= m_rst_n_d;
      m_cs_q    <= m_cs_d;
    end
  end

  assign in_ready    = rst_n && (state_q == S_COLLECT);
  assign res_valid   = (state_q == S_RESULT);
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign m_rst_n     = m_rst_n_q;
  assign m_cs        = m_cs_q;
  assign res_found   = found_q;
  assign res_timeout = timeout_q;
  assign res_ovf     = ovf_q;
  assign res_len     = len_q;
  assign res_idx     = idx_q;

endmodule

// File: tb/tb_word_loader.sv
// tb/tb_word_loader.sv - scoreboard bench for word_loader
module tb_word_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic [3:0] base_addr = 4'd0;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       m_rst_n;
  logic       m_cs;
  logic       m_done = 1'b0;
  logic       m_found = 1'b0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic       res_found;
  logic       res_timeout;
  logic       res_ovf;
  logic [3:0] res_len;
  logic [7:0] res_idx;

  int checks = 0;
  int errors = 0;

  typedef struct { int a; int d; } wr_t;
  typedef struct { int f; int t; int o; int l; int i; } res_t;
  wr_t  exp_wr[$];
  res_t exp_res[$];

  word_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .DELIM(8'h20), .TIMEOUT(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .base_addr(base_addr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .m_rst_n(m_rst_n), .m_cs(m_cs), .m_done(m_done), .m_found(m_found),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_found(res_found), .res_timeout(res_timeout), .res_ovf(res_ovf),
    .res_len(res_len), .res_idx(res_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_wr(input int a, input int d);
    wr_t e;
    e.a = a; e.d = d;
    exp_wr.push_back(e);
  endtask

  task automatic push_res(input int f, input int t, input int o, input int l, input int i);
    res_t e;
    e.f = f; e.t = t; e.o = o; e.l = l; e.i = i;
    exp_res.push_back(e);
  endtask

  // Monitor: every write and every accepted result is checked against the queues.
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      if (exp_wr.size() == 0) begin
        chk("unexpected_write_addr", int'(wr_addr), -1);
      end else begin
        wr_t e;
        e = exp_wr.pop_front();
        chk("wr_addr", int'(wr_addr), e.a);
        chk("wr_data", int'(wr_data), e.d);
      end
    end
    if (rst_n && res_valid && res_ready) begin
      if (exp_res.size() == 0) begin
        chk("unexpected_result_idx", int'(res_idx), -1);
      end else begin
        res_t r;
        r = exp_res.pop_front();
        chk("res_found", int'(res_found), r.f);
        chk("res_timeout", int'(res_timeout), r.t);
        chk("res_ovf", int'(res_ovf), r.o);
        chk("res_len", int'(res_len), r.l);
        chk("res_idx", int'(res_idx), r.i);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    bit rdy;
    int n;
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 50);
    if (!rdy) chk("in_ready_wait", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 0);
    chk({tag, "_wr_en"}, int'(wr_en), 0);
    chk({tag, "_wr_addr"}, int'(wr_addr), 0);
    chk({tag, "_wr_data"}, int'(wr_data), 0);
    chk({tag, "_m_cs"}, int'(m_cs), 0);
    chk({tag, "_m_rst_n"}, int'(m_rst_n), 0);
    chk({tag, "_res_valid"}, int'(res_valid), 0);
    chk({tag, "_res_found"}, int'(res_found), 0);
    chk({tag, "_res_timeout"}, int'(res_timeout), 0);
    chk({tag, "_res_ovf"}, int'(res_ovf), 0);
    chk({tag, "_res_len"}, int'(res_len), 0);
    chk({tag, "_res_idx"}, int'(res_idx), 0);
  endtask

  // Entered in the TERM cycle. mode 0: m_done after 'delay' WAIT cycles;
  // mode 1: matcher silent; mode 2: reset pulse during WAIT.
  task automatic finish_word(input int mode, input int delay, input bit fnd);
    int n;
    @(negedge clk);
    chk("term_m_rst_n", int'(m_rst_n), 1);
    chk("term_m_cs", int'(m_cs), 0);
    @(negedge clk);
    chk("mrst_m_rst_n", int'(m_rst_n), 0);
    chk("mrst_m_cs", int'(m_cs), 0);
    @(negedge clk);
    chk("start_m_cs", int'(m_cs), 1);
    chk("start_m_rst_n", int'(m_rst_n), 1);
    if (mode == 0) begin
      @(posedge clk); #1;
      repeat (delay) begin @(posedge clk); #1; end
      m_done = 1'b1; m_found = fnd;
      @(posedge clk); #1;
      m_done = 1'b0; m_found = 1'b0;
      chk("res_valid_after_done", int'(res_valid), 1);
    end else if (mode == 1) begin
      n = 0;
      @(negedge clk);
      while (!res_valid && n < 400) begin
        chk("wait_m_cs_low", int'(m_cs), 0);
        n++;
        @(negedge clk);
      end
      chk("timeout_latency", n, 256);
      @(posedge clk); #1;
    end else begin
      repeat (4) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_wait");
      @(posedge clk); #1;
      check_reset_outputs("rst_hold");
      rst_n = 1'b1;
      #1;
      chk("rel_in_ready", int'(in_ready), 1);
      chk("rel_m_rst_n", int'(m_rst_n), 0);
      @(posedge clk); #1;
      chk("rel_m_rst_n_edge", int'(m_rst_n), 1);
    end
  endtask

  task automatic accept();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    #1;
    chk("post_reset_in_ready", int'(in_ready), 1);
    chk("post_reset_m_rst_n", int'(m_rst_n), 0);
    @(posedge clk); #1;
    chk("first_edge_m_rst_n", int'(m_rst_n), 1);

    // "cat " at base 4, matcher finds it
    base_addr = 4'd4;
    push_wr(4, 8'h63); push_wr(5, 8'h61); push_wr(6, 8'h74); push_wr(7, 0);
    push_res(1, 0, 0, 3, 0);
    send_str("cat ");
    finish_word(0, 2, 1'b1);
    accept();

    // "  ab " then a trailing space: padding produces nothing
    base_addr = 4'd0;
    push_wr(0, 8'h61); push_wr(1, 8'h62); push_wr(2, 0);
    push_res(0, 0, 0, 2, 1);
    send_str("  ab ");
    finish_word(0, 0, 1'b0);
    accept();
    send_byte(8'h20);

    // 17 'x' then a zero byte: 15 stored, overflow flagged
    for (int i = 0; i < 15; i++) push_wr(i, 8'h78);
    push_wr(15, 0);
    push_res(1, 0, 1, 15, 2);
    repeat (17) send_byte(8'h78);
    send_byte(8'h00);
    finish_word(0, 1, 1'b1);
    accept();

    // matcher never answers: timeout after 256 WAIT cycles
    base_addr = 4'd2;
    push_wr(2, 8'h68); push_wr(3, 8'h69); push_wr(4, 0);
    push_res(0, 1, 0, 2, 3);
    send_str("hi ");
    finish_word(1, 0, 1'b0);
    accept();

    // done on the last timer cycle wins over the timeout
    base_addr = 4'd0;
    push_wr(0, 8'h6f); push_wr(1, 8'h6b); push_wr(2, 0);
    push_res(1, 0, 0, 2, 4);
    send_str("ok ");
    finish_word(0, 255, 1'b1);
    accept();

    // wrapping addresses and a stalled result with bytes waiting
    base_addr = 4'd14;
    push_wr(14, 8'h61); push_wr(15, 8'h62); push_wr(0, 8'h63); push_wr(1, 0);
    push_res(1, 0, 0, 3, 5);
    send_str("abc ");
    finish_word(0, 3, 1'b1);
    in_valid = 1'b1;
    in_data  = 8'h71;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_in_ready", int'(in_ready), 0);
      chk("hold_res_valid", int'(res_valid), 1);
      chk("hold_res_len", int'(res_len), 3);
      chk("hold_res_idx", int'(res_idx), 5);
      chk("hold_res_found", int'(res_found), 1);
      chk("hold_res_timeout", int'(res_timeout), 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    accept();

    base_addr = 4'd0;
    push_wr(0, 8'h7a); push_wr(1, 0);
    push_res(1, 0, 0, 1, 6);
    send_str("z ");
    finish_word(0, 0, 1'b1);
    accept();

    // reset during WAIT abandons the word; the next word starts from index 0
    base_addr = 4'd8;
    push_wr(8, 8'h72); push_wr(9, 8'h73); push_wr(10, 0);
    send_str("rs ");
    finish_word(2, 0, 1'b0);

    base_addr = 4'd0;
    push_wr(0, 8'h67); push_wr(1, 8'h6f); push_wr(2, 0);
    push_res(0, 0, 0, 2, 0);
    send_str("go ");
    finish_word(0, 5, 1'b0);
    accept();

    repeat (3) @(posedge clk);
    #1;
    chk("wr_queue_left", exp_wr.size(), 0);
    chk("res_queue_left", exp_res.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
